pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter for the RISC-V core. It replaces free-running PC+4 stepping with a controlled sequence. Features:
- Issues one instruction-memory request at a time.
- Holds the fetched instruction while decode is stalled.
- Applies branch/jump redirects and trap vectoring, with a fixed priority.
- Drains any in-flight request whose data a redirect has made stale.

It sits between the instruction memory port and the decode stage.

Parameters:
RESET_VEC, 32'h0000_0000, PC loaded at reset.
TRAP_VEC, 32'h0000_0100, PC loaded on trap or misaligned redirect.

Ports:
i_clk  input  1  core clock, rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_stall  input  1  decode cannot accept; hold current o_inst.
i_redirect_vld  input  1  branch/jump taken this cycle.
i_redirect_pc  input  32  redirect target.
i_trap  input  1  exception/interrupt; vector to TRAP_VEC.
o_imem_req  output  1  fetch request valid.
o_imem_addr  output  32  fetch address; stable while o_imem_req=1 and no ack.
i_imem_ack  input  1  request accepted and i_imem_rdata valid this cycle; only meaningful when o_imem_req=1.
i_imem_rdata  input  32  fetched instruction word.
o_inst_vld  output  1  o_inst/o_inst_pc valid for decode.
o_inst  output  32  fetched instruction.
o_inst_pc  output  32  address of o_inst.
o_pc  output  32  next PC to fetch (architectural fetch pointer).
o_misalign  output  1  one-cycle pulse: redirect target had bits[1:0]!=0.

Behaviour:
- Reset (async, while i_rst=1):
  - state=BOOT, o_pc=RESET_VEC, o_imem_addr=RESET_VEC, o_imem_req=0.
  - o_inst_vld=0, o_inst=32'h0000_0013 (NOP), o_inst_pc=0, o_misalign=0.
  - Reset asserted mid-operation aborts everything, including any in-flight request; no drain occurs.
- States: BOOT, REQ, HOLD, DRAIN.
- BOOT: on the first clock after reset release -> REQ with o_imem_req=1, o_imem_addr=o_pc.
- REQ (o_imem_req=1), on i_imem_ack:
  - Next cycle: o_inst<=i_imem_rdata, o_inst_pc<=o_imem_addr, o_inst_vld<=1, o_pc<=o_pc+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
  - If i_stall=0: stay in REQ and issue the next address back-to-back; o_imem_addr<=o_pc+4. Throughput is 1 instruction/cycle with a zero-wait memory.
  - If i_stall=1 at the ack edge: -> HOLD.
  - Without ack, o_inst_vld clears once decode consumes (i_stall=0).
- HOLD:
  - o_imem_req=0; o_inst, o_inst_pc and o_inst_vld are held unchanged while i_stall=1.
  - When i_stall=0: -> REQ at o_pc; o_inst_vld stays 1 for that cycle (consumed).
- Consumption rule: an instruction is consumed on any cycle with o_inst_vld=1 and i_stall=0. No instruction is duplicated or dropped.
- Redirect priority: i_trap > i_redirect_vld > sequential.
  - Valid redirect: o_pc<=target; o_inst_vld<=0 (flush), regardless of i_stall.
  - Trap: o_pc<=TRAP_VEC, same flush.
- Redirect while REQ with no ack:
  - -> DRAIN: o_imem_req stays 1 with the old o_imem_addr until ack.
  - The acked data is discarded (o_inst_vld stays 0), then -> REQ at the new o_pc.
- Redirect in the same cycle as ack: data discarded, -> REQ at the new o_pc directly.
- Redirect in DRAIN: o_pc updated again (latest wins); drain continues.
- Redirect in HOLD or BOOT: flush, -> REQ at the new o_pc.
- Misaligned redirect (i_redirect_pc[1:0]!=0, no trap):
  - Target ignored; o_pc<=TRAP_VEC; o_misalign=1 for exactly one cycle; flush as for a trap.
- i_trap and i_redirect_vld together: trap wins; o_misalign is not raised.

Test Plan:
- Reset release, memory acks every cycle, i_stall=0 -> o_inst_pc sequence 0,4,8,C with o_inst_vld=1 each cycle from the 3rd clock; o_pc leads by 4.
- Ack at 0x8, i_stall=1 for 3 cycles -> o_imem_req=0; o_inst/o_inst_pc=0x8 held 3 cycles; the next fetch is 0xC; no duplicate or missing PC.
- Memory with 2-cycle ack latency; redirect to 0x200 the cycle after the request to 0x10 -> o_imem_addr stays 0x10 until ack; its data is not presented; the next request is 0x200.
- i_trap and i_redirect_vld (0x40) in the same cycle -> o_pc=0x100, o_misalign=0; the next o_inst_pc=0x100.
- Redirect to 0x202 -> o_misalign pulses 1 cycle; the next fetch is at 0x100.
- PC at 0xFFFF_FFFC acked -> o_pc wraps to 0x0. Assert i_rst mid-DRAIN -> all outputs immediately at reset values; after release, fetch restarts at RESET_VEC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - instruction-fetch sequencer owning the core program counter
//
// Issues one instruction-memory request at a time, presents fetched words to
// decode, holds them across decode stalls, applies trap / redirect with
// priority trap > redirect > sequential, and drains any in-flight request
// whose data a redirect has made stale.
//
// Ports:
//   i_clk, i_rst                  clock (rising edge), async active-high reset
//   i_stall                       decode cannot accept the presented instruction
//   i_redirect_vld, i_redirect_pc taken branch/jump and its target
//   i_trap                        exception/interrupt, vector to TRAP_VEC
//   o_imem_req, o_imem_addr       fetch request, address held until acked
//   i_imem_ack, i_imem_rdata      request accepted, instruction word this cycle
//   o_inst_vld, o_inst, o_inst_pc instruction presented to decode
//   o_pc                          architectural fetch pointer
//   o_misalign                    one-cycle pulse for a misaligned redirect target
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_redirect_vld,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_trap,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_vld,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic [31:0] o_pc,
    output logic        o_misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_addr;
    logic [31:0] w_addr_nxt;
    logic [31:0] r_inst;
    logic [31:0] w_inst_nxt;
    logic [31:0] r_inst_pc;
    logic [31:0] w_inst_pc_nxt;
    logic        r_inst_vld;
    logic        w_inst_vld_nxt;
    logic [31:0] r_skid;
    logic [31:0] w_skid_nxt;
    logic [31:0] r_skid_pc;
    logic [31:0] w_skid_pc_nxt;
    logic        r_skid_vld;
    logic        w_skid_vld_nxt;
    logic        r_misalign;

    logic        w_req;
    logic        w_redir;
    logic        w_mis;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    // A trap masks the redirect entirely, so it never reports a misalignment.
    assign w_mis    = i_redirect_vld & ~i_trap & (|i_redirect_pc[1:0]);
    assign w_redir  = i_trap | i_redirect_vld;
    assign w_target = (i_trap | w_mis) ? TRAP_VEC : i_redirect_pc;
    assign w_req    = (r_state == ST_REQ) || (r_state == ST_DRAIN);
    assign w_pc_inc = r_pc + 32'd4;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VEC;
            r_addr     <= RESET_VEC;
            r_inst     <= NOP;
            r_inst_pc  <= 32'h0000_0000;
            r_inst_vld <= 1'b0;
            r_skid     <= NOP;
            r_skid_pc  <= 32'h0000_0000;
            r_skid_vld <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_addr     <= w_addr_nxt;
            r_inst     <= w_inst_nxt;
            r_inst_pc  <= w_inst_pc_nxt;
            r_inst_vld <= w_inst_vld_nxt;
            r_skid     <= w_skid_nxt;
            r_skid_pc  <= w_skid_pc_nxt;
            r_skid_vld <= w_skid_vld_nxt;
            r_misalign <= w_mis;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_addr_nxt     = r_addr;
        w_inst_nxt     = r_inst;
        w_inst_pc_nxt  = r_inst_pc;
        w_inst_vld_nxt = r_inst_vld;
        w_skid_nxt     = r_skid;
        w_skid_pc_nxt  = r_skid_pc;
        w_skid_vld_nxt = r_skid_vld;

        if (w_redir) begin
            // Flush everything already fetched; an unacked request must still
            // complete on the memory side, so it is drained with its old address.
            w_pc_nxt       = w_target;
            w_inst_vld_nxt = 1'b0;
            w_skid_vld_nxt = 1'b0;
            if (w_req && !i_imem_ack) begin
                w_state_nxt = ST_DRAIN;
            end else begin
                w_state_nxt = ST_REQ;
                w_addr_nxt  = w_target;
            end
        end else begin
            unique case (r_state)
                ST_BOOT: begin
                    w_state_nxt = ST_REQ;
                    w_addr_nxt  = r_pc;
                end
                ST_REQ: begin
                    if (i_imem_ack) begin
                        w_pc_nxt   = w_pc_inc;
                        w_addr_nxt = w_pc_inc;
                        if (r_inst_vld && i_stall) begin
                            // Decode still owns the presented word; park the new
                            // one so neither is lost, and stop fetching.
                            w_skid_nxt     = i_imem_rdata;
                            w_skid_pc_nxt  = r_addr;
                            w_skid_vld_nxt = 1'b1;
                            w_state_nxt    = ST_HOLD;
                        end else begin
                            w_inst_nxt     = i_imem_rdata;
                            w_inst_pc_nxt  = r_addr;
                            w_inst_vld_nxt = 1'b1;
                            if (i_stall) begin
                                w_state_nxt = ST_HOLD;
                            end
                        end
                    end else if (r_inst_vld && !i_stall) begin
                        w_inst_vld_nxt = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!i_stall) begin
                        // Presented word is consumed this cycle.
                        w_state_nxt = ST_REQ;
                        w_addr_nxt  = r_pc;
                        if (r_skid_vld) begin
                            w_inst_nxt     = r_skid;
                            w_inst_pc_nxt  = r_skid_pc;
                            w_inst_vld_nxt = 1'b1;
                            w_skid_vld_nxt = 1'b0;
                        end else begin
                            w_inst_vld_nxt = 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Stale data is dropped; nothing is presented meanwhile.
                    if (i_imem_ack) begin
                        w_state_nxt = ST_REQ;
                        w_addr_nxt  = r_pc;
                    end
                end
                default: begin
                    w_state_nxt = ST_BOOT;
                end
            endcase
        end
    end

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_addr;
    assign o_inst_vld  = r_inst_vld;
    assign o_inst      = r_inst;
    assign o_inst_pc   = r_inst_pc;
    assign o_pc        = r_pc;
    assign o_misalign  = r_misalign;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - randomized self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redir_vld;
    logic [31:0] redir_pc;
    logic        trap;
    logic        ack;
    logic [31:0] rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        inst_vld;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc;
    logic        misalign;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(
        .RESET_VEC(RESET_VEC),
        .TRAP_VEC (TRAP_VEC)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_stall       (stall),
        .i_redirect_vld(redir_vld),
        .i_redirect_pc (redir_pc),
        .i_trap        (trap),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ack    (ack),
        .i_imem_rdata  (rdata),
        .o_inst_vld    (inst_vld),
        .o_inst        (inst),
        .o_inst_pc     (inst_pc),
        .o_pc          (pc),
        .o_misalign    (misalign)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    // Reference model: expected next consumed PC, pending o_pc/misalign checks.
    logic [31:0] e_next;
    logic        exp_mis;
    logic        pc_chk;
    logic [31:0] exp_pc;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    int          n_cons;
    int          g_cyc;
    logic        g_tput;

    task automatic model_reset();
        e_next   = RESET_VEC;
        exp_mis  = 1'b0;
        pc_chk   = 1'b0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        g_cyc    = 0;
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        int          r;
        r = int'($urandom_range(7));
        t = 32'($urandom_range(255)) << 2;
        if (r == 0)      t = 32'hFFFF_FFF0;
        else if (r == 1) t = t | 32'($urandom_range(3, 1));
        return t;
    endfunction

    // One cycle: check current outputs, drive inputs, advance the model.
    // force_mode: 0 random, 1 trap+redirect 0x40, 2 redirect 0x202, 3 redirect 0xFFFF_FFF8
    task automatic step(input int p_ack, input int p_stall, input int p_redir,
                        input int p_trap, input int force_mode);
        logic        mis;
        logic [31:0] tgt;
        @(negedge clk);
        g_cyc++;
        chk("misalign", misalign, exp_mis);
        if (pc_chk) chk("pc_after_redirect", pc, exp_pc);
        if (prev_req && !prev_ack) begin
            chk("req_held", imem_req, 1'b1);
            chk("addr_held", imem_addr, prev_addr);
        end
        if (inst_vld) chk("inst_data", inst, mem_word(inst_pc));
        if (g_tput && g_cyc >= 2) begin
            chk("tput_vld", inst_vld, 1'b1);
            chk("tput_pc", inst_pc, 32'(4 * (g_cyc - 2)));
            chk("tput_pc_lead", pc, inst_pc + 32'd4);
        end

        stall     = (int'($urandom_range(99)) < p_stall);
        ack       = imem_req && (int'($urandom_range(99)) < p_ack);
        rdata     = ack ? mem_word(imem_addr) : $urandom;
        trap      = (int'($urandom_range(999)) < p_trap);
        redir_vld = (int'($urandom_range(999)) < p_redir);
        redir_pc  = pick_target();
        if (force_mode == 1) begin
            trap = 1'b1; redir_vld = 1'b1; redir_pc = 32'h0000_0040;
        end else if (force_mode == 2) begin
            trap = 1'b0; redir_vld = 1'b1; redir_pc = 32'h0000_0202;
        end else if (force_mode == 3) begin
            trap = 1'b0; redir_vld = 1'b1; redir_pc = 32'hFFFF_FFF8;
        end

        if (trap || redir_vld) begin
            mis     = !trap && (redir_pc[1:0] != 2'b00);
            tgt     = (trap || mis) ? TRAP_VEC : redir_pc;
            e_next  = tgt;
            exp_pc  = tgt;
            pc_chk  = 1'b1;
            exp_mis = mis;
        end else begin
            pc_chk  = 1'b0;
            exp_mis = 1'b0;
            if (inst_vld && !stall) begin
                chk("consume_pc", inst_pc, e_next);
                e_next = e_next + 32'd4;
                n_cons++;
            end
        end
        prev_req  = imem_req;
        prev_ack  = ack;
        prev_addr = imem_addr;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"}, imem_req, 1'b0);
        chk({tag, "_addr"}, imem_addr, RESET_VEC);
        chk({tag, "_pc"}, pc, RESET_VEC);
        chk({tag, "_vld"}, inst_vld, 1'b0);
        chk({tag, "_inst"}, inst, 32'h0000_0013);
        chk({tag, "_inst_pc"}, inst_pc, 32'h0);
        chk({tag, "_mis"}, misalign, 1'b0);
    endtask

    logic [31:0] a0;

    initial begin
        rst = 1'b1; stall = 1'b0; redir_vld = 1'b0; redir_pc = '0;
        trap = 1'b0; ack = 1'b0; rdata = '0;
        g_tput = 1'b0; n_cons = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Zero-wait memory, no stall: one instruction per cycle from reset.
        g_tput = 1'b1;
        repeat (8) step(100, 0, 0, 0, 0);
        g_tput = 1'b0;

        // Trap and redirect together, then a misaligned redirect.
        step(100, 0, 0, 0, 1);
        repeat (6) step(100, 0, 0, 0, 0);
        step(70, 20, 0, 0, 2);
        repeat (6) step(100, 0, 0, 0, 0);

        // Wrap through the top of the address space.
        step(100, 0, 0, 0, 3);
        repeat (8) step(100, 0, 0, 0, 0);

        // Mixed random traffic.
        n_cons = 0;
        repeat (4000) step(60, 30, 30, 8, 0);
        chk("progress", 32'(n_cons > 500), 32'd1);

        // Reset while draining a stale request.
        for (int i = 0; i < 20 && !imem_req; i++) step(0, 0, 0, 0, 0);
        chk("drain_setup_req", imem_req, 1'b1);
        a0        = imem_addr;
        ack       = 1'b0;
        trap      = 1'b0;
        redir_vld = 1'b1;
        redir_pc  = 32'h0000_0200;
        @(negedge clk);
        chk("drain_req", imem_req, 1'b1);
        chk("drain_addr", imem_addr, a0);
        chk("drain_pc", pc, 32'h0000_0200);
        chk("drain_vld", inst_vld, 1'b0);
        redir_vld = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_vals("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Slow memory after restart; first consumed PC must be RESET_VEC.
        n_cons = 0;
        repeat (2000) step(30, 25, 20, 5, 0);
        chk("progress2", 32'(n_cons > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
